vector_dot_product_seq: RTL



---
 rtl/vector_dot_product_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vector_dot_product_seq.sv
// Sequential dot-product engine: latches two Q16.16 operand vectors on an accepted
// start, multiply-accumulates LANES element pairs per clock and returns a saturated Q16.16 scalar.
module vector_dot_product_seq #(
  parameter int BUFLEN = 128,
  parameter int LANES  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [32*BUFLEN-1:0]  a_vec,
  input  logic [32*BUFLEN-1:0]  b_vec,
  input  logic [31:0]           vlen,
  output logic                  busy,
  output logic [31:0]           result,
  output logic                  done
);

  localparam int LW = $clog2(BUFLEN + 1);
  localparam int IW = $clog2(BUFLEN + LANES + 1);
  localparam logic [31:0] BUFLEN_W = 32'(BUFLEN);
  localparam logic signed [71:0] SAT_MAX = 72'sh00_0000_0000_7FFF_FFFF;
  localparam logic signed [71:0] SAT_MIN = 72'shFF_FFFF_FFFF_8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [32*BUFLEN-1:0]  a_r, a_s;
  logic [32*BUFLEN-1:0]  b_r, b_s;
  logic [LW-1:0]         len_r, len_s;
  logic [IW-1:0]         idx_r, idx_s;
  logic signed [71:0]    acc_r, acc_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic [31:0]           result_r, result_s;

  logic signed [71:0]    lane_sum_s;
  logic signed [71:0]    acc_next_s;
  logic [IW-1:0]         idx_next_s;
  logic                  last_s;
  logic [LW-1:0]         len_clamp_s;

  // Product of element e of both operands; lanes at or past len contribute nothing.
  function automatic logic signed [63:0] lane_product(
    input logic [32*BUFLEN-1:0] a,
    input logic [32*BUFLEN-1:0] b,
    input logic [IW-1:0]        e,
    input logic [LW-1:0]        len
  );
    logic signed [31:0] ea;
    logic signed [31:0] eb;
    logic signed [63:0] xa;
    logic signed [63:0] xb;
    if (32'(e) < 32'(len)) begin
      ea = a[32*int'(e) +: 32];
      eb = b[32*int'(e) +: 32];
      xa = {{32{ea[31]}}, ea};
      xb = {{32{eb[31]}}, eb};
      lane_product = xa * xb;
    end else begin
      lane_product = 64'sd0;
    end
  endfunction

  // Rescale the Q32.32 accumulator to Q16.16 (round toward -inf) and clip to 32 bits.
  function automatic logic [31:0] sat_q16(input logic signed [71:0] acc);
    logic signed [71:0] shifted;
    shifted = acc >>> 16;
    if (shifted > SAT_MAX) begin
      sat_q16 = 32'h7FFF_FFFF;
    end else if (shifted < SAT_MIN) begin
      sat_q16 = 32'h8000_0000;
    end else begin
      sat_q16 = shifted[31:0];
    end
  endfunction

  // Sum of this cycle's lane products and the advanced index.
  always_comb begin
    logic signed [63:0] p;
    lane_sum_s = 72'sd0;
    for (int j = 0; j < LANES; j++) begin
      p = lane_product(a_r, b_r, idx_r + IW'(j), len_r);
      lane_sum_s = lane_sum_s + $signed({{8{p[63]}}, p});
    end
    acc_next_s  = acc_r + lane_sum_s;
    idx_next_s  = idx_r + IW'(LANES);
    last_s      = (32'(idx_next_s) >= 32'(len_r));
    len_clamp_s = (vlen >= BUFLEN_W) ? LW'(BUFLEN) : LW'(vlen);
  end

  // Next-state and next-output logic of the start/MAC/done sequencer.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    len_s    = len_r;
    idx_s    = idx_r;
    acc_s    = acc_r;
    busy_s   = busy_r;
    done_s   = done_r;
    result_s = result_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_s    = a_vec;
          b_s    = b_vec;
          len_s  = len_clamp_s;
          idx_s  = '0;
          acc_s  = 72'sd0;
          if (len_clamp_s == '0) begin
            result_s = 32'h0000_0000;
            done_s   = 1'b1;
            busy_s   = 1'b0;
            state_s  = ST_DONE;
          end else begin
            done_s  = 1'b0;
            busy_s  = 1'b1;
            state_s = ST_MAC;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_MAC: begin
        acc_s = acc_next_s;
        idx_s = idx_next_s;
        // start is deliberately not looked at here: a running job cannot be restarted.
        if (last_s) begin
          result_s = sat_q16(acc_next_s);
          done_s   = 1'b1;
          busy_s   = 1'b0;
          state_s  = ST_DONE;
        end else begin
          busy_s  = 1'b1;
          state_s = ST_MAC;
        end
      end
      default: begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, operand latches, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      len_r    <= '0;
      idx_r    <= '0;
      acc_r    <= 72'sd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      b_r      <= b_s;
      len_r    <= len_s;
      idx_r    <= idx_s;
      acc_r    <= acc_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      result_r <= result_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule
